// File: rtl/encoder_ctrl_pkg.sv
// Shared types and helpers for the encoder measurement controller.
package encoder_ctrl_pkg;

   // Widths of the snapshot payload fields
   localparam int unsigned SNAP_POS_W = 16;
   localparam int unsigned SNAP_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_ARMED  = 2'd1,
      ST_TIMING = 2'd2,
      ST_STALL  = 2'd3
   } period_state_t;

   typedef struct packed {
      logic [SNAP_POS_W-1:0] pos;
      logic [SNAP_CNT_W-1:0] speed;
      logic [SNAP_CNT_W-1:0] period;
   } snap_t;

   // Signed +/-1 step on a w-bit accumulator (carried in 32 bits), clamped at the w-bit limits
   function automatic logic signed [31:0] sat_step(input logic signed [31:0] acc,
                                                   input logic               up,
                                                   input int unsigned        w);
      logic signed [31:0] max_v;
      logic signed [31:0] min_v;
      max_v = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
      min_v = -(32'sd1 <<< (w - 32'd1));
      if (up) begin
         return (acc >= max_v) ? max_v : acc + 32'sd1;
      end
      return (acc <= min_v) ? min_v : acc - 32'sd1;
   endfunction

endpackage

// File: rtl/encoder_period_timer.sv
// Step-to-step period measurement with direction tracking and stall detection.
module encoder_period_timer
   import encoder_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned STALL_CYCLES = 50000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_step,
   input  logic             i_polarity,
   output logic [CNT_W-1:0] o_period,
   output logic             o_dir,
   output logic             o_stalled,
   output logic [CNT_W-1:0] o_period_nxt_c,
   output logic             o_stalled_nxt_c
);

   localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 1);

   period_state_t    state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] period_d;
   logic             dir_q;
   logic             stalled_q;
   logic             stalled_d;
   logic             same_step;
   logic             stall_hit;

   // This cycle's period/stall outcome; also exposed so the snapshot sees post-update values
   always_comb begin
      same_step = 1'b0;
      stall_hit = 1'b0;
      period_d  = period_q;
      stalled_d = stalled_q;
      if (i_en) begin
         case (state_q)
            ST_ARMED, ST_TIMING: begin
               same_step = i_step && (state_q == ST_TIMING) && (i_polarity == dir_q);
               stall_hit = !i_step && (cnt_q == STALL_LAST);
            end
            ST_STALL: begin
               if (i_step) stalled_d = 1'b0;
            end
            default: begin
            end
         endcase
         if (same_step) period_d = cnt_q;
         if (stall_hit) begin
            period_d  = '1;
            stalled_d = 1'b1;
         end
      end
   end

   // Period FSM: any step restarts timing from 1 and records its direction
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_OFF;
         cnt_q     <= '0;
         period_q  <= '0;
         dir_q     <= 1'b0;
         stalled_q <= 1'b0;
      end else begin
         period_q  <= period_d;
         stalled_q <= stalled_d;
         if (!i_en) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_OFF: begin
                  state_q <= ST_ARMED;
                  cnt_q   <= '0;
               end
               ST_ARMED, ST_TIMING, ST_STALL: begin
                  if (i_step) begin
                     state_q <= ST_TIMING;
                     cnt_q   <= CNT_W'(1);
                     dir_q   <= i_polarity;
                  end else if (stall_hit) begin
                     state_q <= ST_STALL;
                  end else if (state_q != ST_STALL) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: state_q <= ST_OFF;
            endcase
         end
      end
   end

   assign o_period        = period_q;
   assign o_dir           = dir_q;
   assign o_stalled       = stalled_q;
   assign o_period_nxt_c  = period_d;
   assign o_stalled_nxt_c = stalled_d;

endmodule

// File: rtl/encoder_speed_ctrl.sv
// Encoder measurement controller: position, windowed speed, period and coherent snapshot port.
module encoder_speed_ctrl
   import encoder_ctrl_pkg::*;
#(
   parameter int unsigned POS_W        = 16,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned WIN_CYCLES   = 1000,
   parameter int unsigned STALL_CYCLES = 50000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_step,
   input  logic             i_polarity,
   input  logic             i_clr_pos,
   input  logic             i_snap_req,
   output logic             o_snap_ack,
   output logic [POS_W-1:0] o_position,
   output logic [CNT_W-1:0] o_win_steps,
   output logic             o_win_valid,
   output logic [CNT_W-1:0] o_period,
   output logic             o_dir,
   output logic             o_stalled,
   output logic [POS_W-1:0] o_snap_pos,
   output logic [CNT_W-1:0] o_snap_speed,
   output logic [CNT_W-1:0] o_snap_period
);

   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYCLES - 1);

   logic [POS_W-1:0]        pos_q;
   logic [POS_W-1:0]        pos_d;
   logic [CNT_W-1:0]        win_cnt_q;
   logic signed [CNT_W-1:0] acc_q;
   logic signed [CNT_W-1:0] acc_step;
   logic [CNT_W-1:0]        win_steps_q;
   logic [CNT_W-1:0]        win_steps_d;
   logic                    win_valid_q;
   logic                    win_end;
   logic                    ack_q;
   logic                    ack_d;
   logic                    done_q;
   logic                    done_d;
   logic                    snap_trig;
   snap_t                   snap_q;
   snap_t                   snap_d;
   logic [CNT_W-1:0]        period_nxt;
   logic                    stalled_nxt;

   encoder_period_timer #(
      .CNT_W        (CNT_W),
      .STALL_CYCLES (STALL_CYCLES)
   ) u_period (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_en            (i_en),
      .i_step          (i_step),
      .i_polarity      (i_polarity),
      .o_period        (o_period),
      .o_dir           (o_dir),
      .o_stalled       (o_stalled),
      .o_period_nxt_c  (period_nxt),
      .o_stalled_nxt_c (stalled_nxt)
   );

   // Next position: clear wins over a coincident step, otherwise modular +/-1
   always_comb begin
      pos_d = pos_q;
      if (i_clr_pos) begin
         pos_d = '0;
      end else if (i_step) begin
         pos_d = i_polarity ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end
   end

   // Window accumulator including this cycle's step, and the value published at window end
   always_comb begin
      acc_step = acc_q;
      if (i_step) acc_step = CNT_W'(sat_step(32'(acc_q), i_polarity, CNT_W));
      win_end     = i_en && (win_cnt_q == WIN_LAST);
      win_steps_d = win_end ? acc_step : win_steps_q;
   end

   // Four-phase handshake; after a capture, req must be seen low with ack low before the next one
   always_comb begin
      snap_trig = i_snap_req && !ack_q && !done_q;
      ack_d     = snap_trig || (ack_q && i_snap_req);
      done_d    = done_q;
      if (snap_trig) begin
         done_d = 1'b1;
      end else if (!i_snap_req && !ack_q) begin
         done_d = 1'b0;
      end
      snap_d = snap_q;
      if (snap_trig) begin
         snap_d.pos    = SNAP_POS_W'(pos_d);
         snap_d.speed  = SNAP_CNT_W'(win_steps_d);
         snap_d.period = stalled_nxt ? '1 : SNAP_CNT_W'(period_nxt);
      end
   end

   // Position, speed window and snapshot registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pos_q       <= '0;
         win_cnt_q   <= '0;
         acc_q       <= '0;
         win_steps_q <= '0;
         win_valid_q <= 1'b0;
         ack_q       <= 1'b0;
         done_q      <= 1'b0;
         snap_q      <= '0;
      end else begin
         pos_q       <= pos_d;
         win_steps_q <= win_steps_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         snap_q      <= snap_d;
         if (!i_en) begin
            win_cnt_q   <= '0;
            acc_q       <= '0;
            win_valid_q <= 1'b0;
         end else if (win_end) begin
            win_cnt_q   <= '0;
            acc_q       <= '0;
            win_valid_q <= 1'b1;
         end else begin
            win_cnt_q   <= win_cnt_q + CNT_W'(1);
            acc_q       <= acc_step;
            win_valid_q <= 1'b0;
         end
      end
   end

   assign o_position    = pos_q;
   assign o_win_steps   = win_steps_q;
   assign o_win_valid   = win_valid_q;
   assign o_snap_ack    = ack_q;
   assign o_snap_pos    = POS_W'(snap_q.pos);
   assign o_snap_speed  = CNT_W'(snap_q.speed);
   assign o_snap_period = CNT_W'(snap_q.period);

endmodule

// File: tb/tb_encoder_speed_ctrl.sv
// Self-checking bench for encoder_speed_ctrl: directed tables, corner sequences and random traffic vs a model.
module tb_encoder_speed_ctrl;

   localparam int unsigned POS_W = 16;
   localparam int unsigned CNT_W = 16;
   localparam int          WIN   = 10;
   localparam int          STALL = 20;
   localparam int          M_OFF = 0;
   localparam int          M_RUN = 1;
   localparam int          M_STL = 2;

   logic             clk = 1'b0;
   logic             rst, en, step, pol, clr, req;
   logic             snap_ack, win_valid, dir, stalled;
   logic [POS_W-1:0] position, snap_pos;
   logic [CNT_W-1:0] win_steps, period, snap_speed, snap_period;

   encoder_speed_ctrl #(
      .POS_W        (POS_W),
      .CNT_W        (CNT_W),
      .WIN_CYCLES   (WIN),
      .STALL_CYCLES (STALL)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_step        (step),
      .i_polarity    (pol),
      .i_clr_pos     (clr),
      .i_snap_req    (req),
      .o_snap_ack    (snap_ack),
      .o_position    (position),
      .o_win_steps   (win_steps),
      .o_win_valid   (win_valid),
      .o_period      (period),
      .o_dir         (dir),
      .o_stalled     (stalled),
      .o_snap_pos    (snap_pos),
      .o_snap_speed  (snap_speed),
      .o_snap_period (snap_period)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int now    = 0;

   // Behavioural model state: times and plain integers
   int m_pos, m_en_start, m_acc, m_win_steps, m_mode, m_ref, m_period;
   int m_snap_pos, m_snap_speed, m_snap_period;
   bit m_run, m_win_valid, m_seen, m_dir, m_stalled, m_ack, m_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
      end
   endtask

   task automatic model_step();
      int delta;
      bit trig;
      delta = step ? (pol ? 1 : -1) : 0;
      if (rst) begin
         m_pos = 0; m_run = 0; m_acc = 0; m_win_steps = 0; m_win_valid = 0;
         m_mode = M_OFF; m_seen = 0; m_ref = 0; m_dir = 0; m_period = 0; m_stalled = 0;
         m_ack = 0; m_done = 0; m_snap_pos = 0; m_snap_speed = 0; m_snap_period = 0;
      end else begin
         m_pos = clr ? 0 : ((m_pos + delta) & 32'hFFFF);
         if (en) begin
            if (!m_run) begin
               m_run = 1; m_en_start = now; m_acc = 0;
            end
            m_acc += delta;
            if (m_acc > 32767) m_acc = 32767;
            if (m_acc < -32768) m_acc = -32768;
            if ((now - m_en_start) % WIN == WIN - 1) begin
               m_win_steps = m_acc; m_acc = 0; m_win_valid = 1;
            end else begin
               m_win_valid = 0;
            end
         end else begin
            m_run = 0; m_acc = 0; m_win_valid = 0;
         end
         if (!en) begin
            m_mode = M_OFF;
         end else if (m_mode == M_OFF) begin
            m_mode = M_RUN; m_seen = 0; m_ref = now + 1;
         end else if (m_mode == M_STL) begin
            if (step) begin
               m_mode = M_RUN; m_seen = 1; m_ref = now; m_dir = pol; m_stalled = 0;
            end
         end else if (step) begin
            if (m_seen && pol == m_dir) m_period = now - m_ref;
            m_dir = pol; m_seen = 1; m_ref = now;
         end else if (now - m_ref == STALL - 1) begin
            m_mode = M_STL; m_stalled = 1; m_period = 32'hFFFF;
         end
         trig = req && !m_ack && !m_done;
         if (trig) begin
            m_snap_pos    = m_pos;
            m_snap_speed  = m_win_steps & 32'hFFFF;
            m_snap_period = m_stalled ? 32'hFFFF : m_period;
         end
         if (trig) m_done = 1;
         else if (!req && !m_ack) m_done = 0;
         m_ack = trig || (m_ack && req);
      end
      now++;
   endtask

   task automatic compare_all();
      chk("position",    32'(position),    32'(m_pos));
      chk("win_steps",   32'(win_steps),   m_win_steps & 32'hFFFF);
      chk("win_valid",   32'(win_valid),   32'(m_win_valid));
      chk("period",      32'(period),      32'(m_period));
      chk("dir",         32'(dir),         32'(m_dir));
      chk("stalled",     32'(stalled),     32'(m_stalled));
      chk("snap_ack",    32'(snap_ack),    32'(m_ack));
      chk("snap_pos",    32'(snap_pos),    32'(m_snap_pos));
      chk("snap_speed",  32'(snap_speed),  32'(m_snap_speed));
      chk("snap_period", 32'(snap_period), 32'(m_snap_period));
   endtask

   task automatic cycle(input bit r, input bit e, input bit s, input bit p, input bit c, input bit q);
      rst = r; en = e; step = s; pol = p; clr = c; req = q;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit          step;
      bit          pol;
      logic [15:0] pos;
      logic [15:0] period;
      bit          dir;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int first_valid;
      int gap;
      bit r, e, s, p, c, q;

      // Reversal table: fwd at 1, fwd at 5, rev at 8, rev at 15 (en held high from row 0)
      tbl[0]  = '{1'b0, 1'b0, 16'd0, 16'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 16'd1, 16'd0, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 16'd1, 16'd0, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 16'd1, 16'd0, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 16'd1, 16'd0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 16'd2, 16'd4, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 16'd2, 16'd4, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 16'd2, 16'd4, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 16'd1, 16'd4, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 16'd1, 16'd4, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 16'd1, 16'd4, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 16'd1, 16'd4, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 16'd1, 16'd4, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 16'd1, 16'd4, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 16'd1, 16'd4, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 16'd0, 16'd7, 1'b0};

      // Reset state
      do_reset();
      chk("rst_position", 32'(position), 0);
      chk("rst_win_steps", 32'(win_steps), 0);
      chk("rst_period", 32'(period), 0);
      chk("rst_stalled", 32'(stalled), 0);
      chk("rst_ack", 32'(snap_ack), 0);

      // Forward steps every 4 cycles
      for (int t = 0; t < 40; t++) begin
         cycle(0, 1, (t % 4) == 1, 1, 0, 0);
         if (win_valid) chk("t1_win_2or3", 32'(win_steps == 16'd2 || win_steps == 16'd3), 1);
      end
      chk("t1_period", 32'(period), 4);
      chk("t1_dir", 32'(dir), 1);
      chk("t1_position", 32'(position), 10);

      // Position wrap and clear-over-step priority
      do_reset();
      for (int i = 0; i < 32767; i++) cycle(0, 0, 1, 1, 0, 0);
      chk("t2_pos_max", 32'(position), 32'h7FFF);
      cycle(0, 0, 1, 1, 0, 0);
      chk("t2_pos_wrap", 32'(position), 32'h8000);
      cycle(0, 0, 1, 0, 1, 0);
      chk("t2_clr_pos", 32'(position), 0);

      // Stall and recovery: steps at 1,6,11 then silence, then 33 and 39
      do_reset();
      for (int t = 0; t < 42; t++) begin
         cycle(0, 1, (t == 1 || t == 6 || t == 11 || t == 33 || t == 39), 1, 0, 0);
         if (t == 11) chk("t3_period5", 32'(period), 5);
         if (t == 29) chk("t3_not_yet_stalled", 32'(stalled), 0);
         if (t == 30) begin
            chk("t3_stalled", 32'(stalled), 1);
            chk("t3_period_ones", 32'(period), 32'hFFFF);
         end
         if (t == 33) begin
            chk("t3_unstalled", 32'(stalled), 0);
            chk("t3_period_still_ones", 32'(period), 32'hFFFF);
         end
         if (t == 39) chk("t3_period6", 32'(period), 6);
      end

      // Direction reversal table
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cycle(0, 1, tbl[i].step, tbl[i].pol, 0, 0);
         chk("tbl_pos", 32'(position), 32'(tbl[i].pos));
         chk("tbl_period", 32'(period), 32'(tbl[i].period));
         chk("tbl_dir", 32'(dir), 32'(tbl[i].dir));
      end

      // Snapshot handshake with a step every cycle
      do_reset();
      for (int t = 0; t < 5; t++) cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 1, 1, 1, 0, 1);
      chk("t5_ack_rise", 32'(snap_ack), 1);
      chk("t5_snap_pos", 32'(snap_pos), 6);
      chk("t5_snap_period", 32'(snap_period), 1);
      for (int t = 0; t < 3; t++) cycle(0, 1, 1, 1, 0, 1);
      chk("t5_ack_held", 32'(snap_ack), 1);
      chk("t5_no_recapture", 32'(snap_pos), 6);
      cycle(0, 1, 1, 1, 0, 0);
      chk("t5_ack_fall", 32'(snap_ack), 0);
      cycle(0, 1, 1, 1, 0, 1);
      chk("t5_no_early_ack", 32'(snap_ack), 0);
      cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 1, 1, 1, 0, 1);
      chk("t5_second_ack", 32'(snap_ack), 1);
      chk("t5_second_pos", 32'(snap_pos), 13);
      chk("t5_second_speed", 32'(snap_speed), 10);

      // Reset mid-window with ack high, then first window after re-enable
      do_reset();
      for (int t = 0; t < 4; t++) cycle(0, 1, 1, 0, 0, 1);
      chk("t6_ack_before", 32'(snap_ack), 1);
      cycle(1, 1, 1, 0, 0, 1);
      chk("t6_ack_clr", 32'(snap_ack), 0);
      chk("t6_pos_clr", 32'(position), 0);
      chk("t6_snap_pos_clr", 32'(snap_pos), 0);
      chk("t6_dir_clr", 32'(dir), 0);
      first_valid = -1;
      for (int k = 1; k <= 15; k++) begin
         cycle(0, 1, 0, 0, 0, 0);
         if (win_valid && first_valid < 0) first_valid = k;
      end
      chk("t6_first_valid", first_valid, 10);

      // Randomized traffic against the model
      do_reset();
      gap = 2;
      p = 1'b1;
      q = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 100 == 0) begin
            case ($urandom_range(0, 2))
               0:       gap = 2;
               1:       gap = 8;
               default: gap = 40;
            endcase
         end
         r = ($urandom_range(0, 299) == 0);
         e = ($urandom_range(0, 29) != 0);
         s = ($urandom_range(0, gap - 1) == 0);
         if ($urandom_range(0, 7) == 0) p = ~p;
         c = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 5) == 0) q = ~q;
         cycle(r, e, s, p, c, q);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/encoder_speed_ctrl.md
Name: encoder_speed_ctrl

Overview:
Measurement controller downstream of the quadrature encoder step decoder. It consumes the single-cycle step/polarity pulses and maintains four quantities:
- a wrapping signed position
- a signed step count per fixed time window (speed)
- the step-to-step period, with stall detection
- an atomic snapshot port for the motor-control/register layer, via a 4-phase req/ack handshake.

Parameters:
POS_W, 16, position counter width (two's complement, wraps)
CNT_W, 16, width of window step count (signed) and period counter (unsigned)
WIN_CYCLES, 1000, clock cycles per speed window; 2 <= WIN_CYCLES <= 2^CNT_W
STALL_CYCLES, 50000, cycles without a step before stall is declared; 2 <= STALL_CYCLES <= 2^CNT_W-1

Ports:
i_clk  in  1  master clock
i_rst  in  1  reset; one clock, reset is synchronous and active-high
i_en  in  1  measurement enable (level)
i_step  in  1  single-cycle step pulse from decoder
i_polarity  in  1  step direction, 1 = forward (+1), 0 = reverse (-1)
i_clr_pos  in  1  clear position pulse
i_snap_req  in  1  snapshot request (4-phase)
o_snap_ack  out  1  snapshot acknowledge
o_position  out  POS_W  live signed position
o_win_steps  out  CNT_W  signed steps counted in last completed window
o_win_valid  out  1  1-cycle pulse when o_win_steps updates
o_period  out  CNT_W  cycles between last two same-direction steps
o_dir  out  1  direction of last step
o_stalled  out  1  no step for STALL_CYCLES
o_snap_pos  out  POS_W  captured position
o_snap_speed  out  CNT_W  captured o_win_steps
o_snap_period  out  CNT_W  captured o_period; all-ones if stalled at capture

Behaviour:
- Reset: all outputs 0; FSM in ST_OFF; all internal counters 0.
- Latency: step at cycle n affects o_position, o_period and o_dir at n+1. No input registering; inputs are synchronous to i_clk.
- Position:
  - Updated whenever a step occurs, independent of i_en: +1 or -1 with modular wrap (0x7FFF+1 -> 0x8000).
  - i_clr_pos has priority: the position becomes 0 and a coincident step is discarded.
- Speed window:
  - Runs only while i_en=1.
  - The cycle counter counts 0..WIN_CYCLES-1.
  - The signed accumulator adds ±1 per step and saturates at the CNT_W signed limits.
  - In the cycle the counter equals WIN_CYCLES-1:
    - o_win_steps <= acc + this cycle's step contribution (saturated)
    - acc <= 0, counter <= 0
    - o_win_valid = 1 for that one cycle.
  - i_en=0 clears the counter and acc; o_win_steps is held.
- Period FSM, states ST_OFF, ST_ARMED, ST_TIMING, ST_STALL:
  - Any state, i_en=0 -> ST_OFF. The period counter clears; o_period, o_dir and o_stalled are held.
  - ST_OFF, i_en=1 -> ST_ARMED; period counter = 0.
  - ST_ARMED:
    - On a step -> ST_TIMING; counter = 1; o_dir <= polarity.
    - Counter reaching STALL_CYCLES-1 -> ST_STALL.
  - ST_TIMING, counter increments each cycle:
    - Step with polarity == o_dir: o_period <= counter; counter = 1.
    - Step with polarity != o_dir (reversal): o_dir updated; counter = 1; o_period held.
    - Counter reaching STALL_CYCLES-1 with no step: -> ST_STALL; o_stalled=1; o_period <= all-ones.
  - ST_STALL:
    - Step -> ST_TIMING; o_stalled=0; counter = 1; o_dir updated; o_period stays all-ones until the next completed interval.
  - A step in the same cycle as the stall threshold counts as a step; no stall is declared.
- Snapshot handshake:
  - Trigger: i_snap_req=1 and o_snap_ack=0 → next cycle:
    - o_snap_* capture the values the live outputs take in that same cycle (post-update, coherent)
    - o_snap_ack=1.
  - o_snap_ack stays high while i_snap_req=1.
  - i_snap_req=0 → o_snap_ack clears the next cycle.
  - o_snap_* hold between captures.
  - A new capture needs req low to be seen with ack low first.
  - The snapshot works regardless of i_en.
- Reset mid-operation (i_rst high in any cycle) restores all reset values next cycle, including a pending ack.

Decomposition:
- Package encoder_ctrl_pkg holds:
  - the period_state_t enum (ST_OFF, ST_ARMED, ST_TIMING, ST_STALL)
  - a saturating signed ±1 add function
  - the snapshot struct (pos, speed, period).
- Sub-module encoder_period_timer: period FSM, counter and stall detection, with outputs o_period, o_dir and o_stalled.
- The top level holds position, window, snapshot and handshake logic.

Test Plan:
Use WIN_CYCLES=10 and STALL_CYCLES=20 for the bench.
1. Forward steps every 4 cycles, i_en=1 → o_period=4, o_dir=1; each o_win_valid pulse shows o_win_steps of 2 or 3; o_position increments by 1 per step.
2. Position at 0x7FFF, one forward step → 0x8000. Then i_clr_pos together with a reverse step → o_position=0.
3. Steps every 5 cycles, then none for 20 cycles → o_stalled=1 and o_period=0xFFFF at the threshold cycle. The next step → o_stalled=0 with o_period still 0xFFFF; a second step 6 cycles later → o_period=6.
4. Forward, forward, then reverse step at +3 cycles → o_dir=0 and o_period unchanged; a reverse step at +7 → o_period=7.
5. Raise i_snap_req while steps occur every cycle → o_snap_ack one cycle later, o_snap_* equal to the live outputs of that cycle. Held req produces no recapture; req low → ack low next cycle.
6. i_rst asserted mid-window with ack high → all outputs 0 next cycle; FSM ST_OFF; first o_win_valid appears 10 cycles after i_en re-asserts.
